// File: rtl/significand_mul_seq.sv
// Sequential significand multiplier: radix-2 shift-add product,
// leading-zero normalisation and IEEE-style rounding of the fraction.
module significand_mul_seq #(
    parameter int MW = 24,
    localparam int SW = $clog2(2 * MW)
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [MW-1:0] Mx,
    input  logic [MW-1:0] My,
    input  logic [1:0]    R_mode,
    input  logic          Sz,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [MW-2:0] Mz,
    output logic          ovf,
    output logic [SW-1:0] SHL,
    output logic          Overflow_after_round,
    output logic          inexact,
    output logic          zero
);

    localparam int CW = $clog2(MW);
    localparam int PW = 2 * MW;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL,
        S_NORM,
        S_ROUND,
        S_DONE
    } state_t;

    state_t          r_state;
    logic [MW-1:0]   r_a;
    logic [MW-1:0]   r_b;
    logic [PW-1:0]   r_prod;
    logic [CW-1:0]   r_cnt;
    logic [1:0]      r_rm;
    logic            r_sz;

    logic [MW-2:0]   r_frac;
    logic            r_g;
    logic            r_s;
    logic            r_nov;
    logic [SW-1:0]   r_nshl;
    logic            r_nzero;

    logic            r_in_ready;
    logic            r_out_valid;
    logic [MW-2:0]   r_mz;
    logic            r_ovf;
    logic [SW-1:0]   r_shl;
    logic            r_oar;
    logic            r_inx;
    logic            r_zero;

    logic [PW-1:0]   w_pp;
    logic [SW-1:0]   w_lz;
    logic [PW-3:0]   w_qn;
    logic            w_top;
    logic            w_pz;
    logic [MW-2:0]   w_frac;
    logic            w_g;
    logic            w_s;
    logic            w_inc;
    logic [MW-1:0]   w_sum;

    assign w_pp  = r_b[r_cnt] ? {{MW{1'b0}}, r_a} : '0;
    assign w_top = r_prod[PW-1];
    assign w_pz  = (r_prod == '0);
    assign w_qn  = r_prod[PW-3:0] << w_lz;

    // Leading zeros below the overflow bit; highest set bit wins.
    always_comb begin
        w_lz = '0;
        for (int i = 0; i < PW - 1; i++) begin
            if (r_prod[i]) w_lz = SW'(PW - 2 - i);
        end
    end

    // Pick fraction, guard and sticky from the raw or shifted product.
    always_comb begin
        if (w_top) begin
            w_frac = r_prod[PW-2:MW];
            w_g    = r_prod[MW-1];
            w_s    = |r_prod[MW-2:0];
        end else begin
            w_frac = w_qn[PW-3:MW-1];
            w_g    = w_qn[MW-2];
            w_s    = |w_qn[MW-3:0];
        end
    end

    // Rounding increment decision for the captured mode and sign.
    always_comb begin
        w_inc = 1'b0;
        unique case (r_rm)
            2'b00: w_inc = r_g & (r_s | r_frac[0]);
            2'b01: w_inc = 1'b0;
            2'b10: w_inc = (r_g | r_s) & ~r_sz;
            2'b11: w_inc = (r_g | r_s) & r_sz;
            default: w_inc = 1'b0;
        endcase
        w_sum = {1'b0, r_frac} + {{(MW-1){1'b0}}, w_inc};
    end

    // Control FSM with datapath registers and registered outputs.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state     <= S_IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_prod      <= '0;
            r_cnt       <= '0;
            r_rm        <= '0;
            r_sz        <= 1'b0;
            r_frac      <= '0;
            r_g         <= 1'b0;
            r_s         <= 1'b0;
            r_nov       <= 1'b0;
            r_nshl      <= '0;
            r_nzero     <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_mz        <= '0;
            r_ovf       <= 1'b0;
            r_shl       <= '0;
            r_oar       <= 1'b0;
            r_inx       <= 1'b0;
            r_zero      <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_a        <= Mx;
                        r_b        <= My;
                        r_rm       <= R_mode;
                        r_sz       <= Sz;
                        r_prod     <= '0;
                        r_cnt      <= CW'(MW - 1);
                        r_in_ready <= 1'b0;
                        r_state    <= S_MUL;
                    end
                end
                S_MUL: begin
                    r_prod <= {r_prod[PW-2:0], 1'b0} + w_pp;
                    if (r_cnt == '0) begin
                        r_state <= S_NORM;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_NORM: begin
                    r_frac  <= w_frac;
                    r_g     <= w_g;
                    r_s     <= w_s;
                    r_nov   <= w_top;
                    r_nshl  <= w_top ? '0 : w_lz;
                    r_nzero <= w_pz;
                    r_state <= S_ROUND;
                end
                S_ROUND: begin
                    r_mz        <= w_sum[MW-1] ? '0 : w_sum[MW-2:0];
                    r_oar       <= w_sum[MW-1];
                    r_inx       <= r_g | r_s;
                    r_ovf       <= r_nov;
                    r_shl       <= r_nshl;
                    r_zero      <= r_nzero;
                    r_out_valid <= 1'b1;
                    r_state     <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready             = r_in_ready;
    assign out_valid            = r_out_valid;
    assign Mz                   = r_mz;
    assign ovf                  = r_ovf;
    assign SHL                  = r_shl;
    assign Overflow_after_round = r_oar;
    assign inexact              = r_inx;
    assign zero                 = r_zero;

endmodule

// File: tb/tb_significand_mul_seq.sv
// Bench for significand_mul_seq: directed vector table, random
// vectors against an arithmetic reference, reset and stall sequences.
module tb_significand_mul_seq;

    typedef struct packed {
        logic [22:0] mz;
        logic        ovf;
        logic [5:0]  shl;
        logic        oar;
        logic        inx;
        logic        zero;
    } exp_t;

    typedef struct {
        logic [23:0] mx;
        logic [23:0] my;
        logic [1:0]  rm;
        logic        sz;
        exp_t        e;
    } vec_t;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [23:0] Mx = '0;
    logic [23:0] My = '0;
    logic [1:0]  R_mode = '0;
    logic        Sz = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [22:0] Mz;
    logic        ovf;
    logic [5:0]  SHL;
    logic        Overflow_after_round;
    logic        inexact;
    logic        zero;

    int   checks = 0;
    int   failures = 0;
    exp_t sb_q[$];

    significand_mul_seq #(.MW(24)) dut (
        .CLK(CLK),
        .RST(RST),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .Mx(Mx),
        .My(My),
        .R_mode(R_mode),
        .Sz(Sz),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .Mz(Mz),
        .ovf(ovf),
        .SHL(SHL),
        .Overflow_after_round(Overflow_after_round),
        .inexact(inexact),
        .zero(zero)
    );

    always #5 CLK = ~CLK;

    function automatic exp_t cur();
        exp_t r;
        r = {Mz, ovf, SHL, Overflow_after_round, inexact, zero};
        return r;
    endfunction

    function automatic exp_t model(input logic [23:0] a, input logic [23:0] b,
                                   input logic [1:0] rm, input logic sz);
        logic [47:0] p;
        logic [47:0] q;
        logic [22:0] f;
        logic        g;
        logic        s;
        logic        inc;
        logic [23:0] sum;
        exp_t        r;
        r = '0;
        p = 48'(a) * 48'(b);
        if (p == 48'd0) begin
            r.zero = 1'b1;
            return r;
        end
        if (p[47]) begin
            r.ovf = 1'b1;
            f = p[46:24];
            g = p[23];
            s = |p[22:0];
        end else begin
            q = p;
            while (!q[46]) begin
                q = q << 1;
                r.shl = r.shl + 6'd1;
            end
            f = q[45:23];
            g = q[22];
            s = |q[21:0];
        end
        case (rm)
            2'b00: inc = g & (s | f[0]);
            2'b01: inc = 1'b0;
            2'b10: inc = (g | s) & ~sz;
            default: inc = (g | s) & sz;
        endcase
        sum = {1'b0, f} + 24'(inc);
        r.oar = sum[23];
        r.mz = sum[23] ? 23'd0 : sum[22:0];
        r.inx = g | s;
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] got,
                       input logic [63:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    task automatic noise_drive(input int mode);
        if (mode == 1) begin
            in_valid = 1'($urandom_range(1));
            Mx = $urandom;
            My = $urandom;
            R_mode = 2'($urandom);
        end else if (mode == 2) begin
            in_valid = 1'b1;
            Mx = $urandom;
            My = $urandom;
        end
    endtask

    // Called at a negedge with the block expected idle.
    task automatic run_op(input string name, input vec_t v, input int stall,
                          input int noise);
        int   lat;
        int   n;
        bit   bad;
        exp_t got;
        exp_t want;
        n = 0;
        while (!in_ready && n < 100) begin
            @(negedge CLK);
            n++;
        end
        if (!in_ready) begin
            chk({name, "_ready_timeout"}, 64'(in_ready), 64'd1);
            return;
        end
        Mx = v.mx;
        My = v.my;
        R_mode = v.rm;
        Sz = v.sz;
        in_valid = 1'b1;
        @(posedge CLK);
        sb_q.push_back(v.e);
        lat = 0;
        bad = 1'b0;
        @(negedge CLK);
        in_valid = 1'b0;
        noise_drive(noise);
        while (!out_valid && lat < 60) begin
            if (in_ready) bad = 1'b1;
            @(posedge CLK);
            lat++;
            @(negedge CLK);
            if (!out_valid) noise_drive(noise);
        end
        chk({name, "_latency"}, 64'(lat), 64'd26);
        chk({name, "_busy_not_ready"}, 64'(bad), 64'd0);
        if (!out_valid || sb_q.size() == 0) begin
            sb_q.delete();
            in_valid = 1'b0;
            return;
        end
        got = cur();
        want = sb_q.pop_front();
        chk({name, "_result"}, 64'(got), 64'(want));
        bad = 1'b0;
        for (int k = 0; k < stall; k++) begin
            noise_drive(noise);
            @(posedge CLK);
            @(negedge CLK);
            if (cur() !== got || !out_valid || in_ready) bad = 1'b1;
        end
        if (stall > 0) chk({name, "_stall_stable"}, 64'(bad), 64'd0);
        out_ready = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        out_ready = 1'b0;
        in_valid = 1'b0;
        chk({name, "_release"}, {62'd0, out_valid, in_ready}, 64'd1);
    endtask

    vec_t tbl[14];
    vec_t v;

    initial begin
        tbl[0]  = '{24'h800000, 24'h800000, 2'b00, 1'b0, '{23'h000000, 1'b0, 6'd0,  1'b0, 1'b0, 1'b0}};
        tbl[1]  = '{24'hFFFFFE, 24'h800001, 2'b00, 1'b0, '{23'h000000, 1'b0, 6'd0,  1'b1, 1'b1, 1'b0}};
        tbl[2]  = '{24'hFFFFFE, 24'h800001, 2'b01, 1'b0, '{23'h7FFFFF, 1'b0, 6'd0,  1'b0, 1'b1, 1'b0}};
        tbl[3]  = '{24'h400000, 24'h400000, 2'b00, 1'b0, '{23'h000000, 1'b0, 6'd2,  1'b0, 1'b0, 1'b0}};
        tbl[4]  = '{24'h000000, 24'h123456, 2'b00, 1'b0, '{23'h000000, 1'b0, 6'd0,  1'b0, 1'b0, 1'b1}};
        tbl[5]  = '{24'h000001, 24'h000001, 2'b00, 1'b0, '{23'h000000, 1'b0, 6'd46, 1'b0, 1'b0, 1'b0}};
        tbl[6]  = '{24'h800001, 24'hC00000, 2'b00, 1'b0, '{23'h400002, 1'b0, 6'd0,  1'b0, 1'b1, 1'b0}};
        tbl[7]  = '{24'hFF0100, 24'h404000, 2'b00, 1'b0, '{23'h000000, 1'b0, 6'd0,  1'b0, 1'b1, 1'b0}};
        tbl[8]  = '{24'hFF0100, 24'h404000, 2'b10, 1'b0, '{23'h000001, 1'b0, 6'd0,  1'b0, 1'b1, 1'b0}};
        tbl[9]  = '{24'hFFFFFF, 24'hFFFFFF, 2'b10, 1'b0, '{23'h7FFFFF, 1'b1, 6'd0,  1'b0, 1'b1, 1'b0}};
        tbl[10] = '{24'hFFFFFF, 24'hFFFFFF, 2'b11, 1'b0, '{23'h7FFFFE, 1'b1, 6'd0,  1'b0, 1'b1, 1'b0}};
        tbl[11] = '{24'hFFFFFF, 24'hFFFFFF, 2'b11, 1'b1, '{23'h7FFFFF, 1'b1, 6'd0,  1'b0, 1'b1, 1'b0}};
        tbl[12] = '{24'hFFFFFF, 24'hFFFFFF, 2'b10, 1'b1, '{23'h7FFFFE, 1'b1, 6'd0,  1'b0, 1'b1, 1'b0}};
        tbl[13] = '{24'hFFFFFF, 24'hFFFFFF, 2'b00, 1'b0, '{23'h7FFFFE, 1'b1, 6'd0,  1'b0, 1'b1, 1'b0}};

        repeat (2) @(negedge CLK);
        chk("in_reset", 64'(cur()), 64'd0);
        RST = 1'b0;
        chk("reset_hs", {62'd0, out_valid, in_ready}, 64'd1);

        for (int i = 0; i < 14; i++) begin
            run_op($sformatf("vec%0d", i), tbl[i], 0, i % 2);
        end

        // Abort an operation mid-multiply; last result is nonzero.
        Mx = 24'hFFFFFF;
        My = 24'hFFFFFF;
        R_mode = 2'b00;
        in_valid = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        in_valid = 1'b0;
        repeat (9) @(posedge CLK);
        #2 RST = 1'b1;
        #1;
        chk("rst_async_out", 64'(cur()), 64'd0);
        chk("rst_async_hs", {62'd0, out_valid, in_ready}, 64'd1);
        @(negedge CLK);
        RST = 1'b0;
        begin
            bit seen;
            seen = 1'b0;
            for (int k = 0; k < 40; k++) begin
                @(negedge CLK);
                if (out_valid) seen = 1'b1;
            end
            chk("rst_no_valid", 64'(seen), 64'd0);
        end
        run_op("after_rst", tbl[13], 0, 0);

        // Long stall in DONE with in_valid held high.
        run_op("stall5", tbl[6], 5, 2);

        for (int i = 0; i < 20; i++) begin
            v.mx = $urandom;
            v.my = $urandom;
            if (i % 5 == 0) v.mx = v.mx >> $urandom_range(23);
            v.rm = 2'($urandom);
            v.sz = 1'($urandom);
            v.e = model(v.mx, v.my, v.rm, v.sz);
            run_op($sformatf("rnd%0d", i), v, $urandom_range(3), i % 3);
        end

        chk("scoreboard_empty", 64'(sb_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
